// File: rtl/cpu_pkg.sv
// ---------------------------------------------------------------------------
// cpu_pkg
//   Shared CPU definitions: architectural widths and the instruction fetch
//   FSM state encoding. Imported by pipeline stages that need them.
// ---------------------------------------------------------------------------
package cpu_pkg;

    localparam int XLEN   = 64;  // address / PC width
    localparam int INSN_W = 32;  // instruction word width

    // Instruction fetch FSM
    //   FETCH_REQ  : request driven to instruction memory
    //   FETCH_WAIT : one request outstanding, waiting for its word
    //   FETCH_HOLD : word received while decode stalled, buffered locally
    //   FETCH_DROP : outstanding response belongs to a flushed path
    typedef enum logic [1:0] {
        FETCH_REQ  = 2'd0,
        FETCH_WAIT = 2'd1,
        FETCH_HOLD = 2'd2,
        FETCH_DROP = 2'd3
    } fetch_state_e;

endpackage

// File: rtl/fetch_unit.sv
// ---------------------------------------------------------------------------
// fetch_unit
//   Instruction fetch stage. Issues one instruction-memory request at a
//   time, hands each returned word to the IF/ID register with its PC, holds
//   the word while decode is stalled, and flushes on branch/jump redirects.
//
// Ports
//   clk             : clock, all state updates on the rising edge
//   reset_n         : asynchronous active-low reset
//   imem_req_valid  : fetch request valid (only in FETCH_REQ)
//   imem_req_ready  : memory accepts the request this cycle
//   imem_req_addr   : fetch byte address (current fetch PC)
//   imem_resp_valid : instruction word returned this cycle
//   imem_resp_data  : returned instruction word
//   stall           : decode cannot take a new instruction
//   redirect_valid  : taken branch/jump, flush and refetch
//   redirect_pc     : new fetch address
//   instruction_out : instruction to the IF/ID register
//   pc_out          : address of instruction_out
//   valid_out       : instruction_out/pc_out carry a new instruction
// ---------------------------------------------------------------------------
module fetch_unit
    import cpu_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = 64'h0
) (
    input  logic              clk,
    input  logic              reset_n,
    output logic              imem_req_valid,
    input  logic              imem_req_ready,
    output logic [XLEN-1:0]   imem_req_addr,
    input  logic              imem_resp_valid,
    input  logic [INSN_W-1:0] imem_resp_data,
    input  logic              stall,
    input  logic              redirect_valid,
    input  logic [XLEN-1:0]   redirect_pc,
    output logic [INSN_W-1:0] instruction_out,
    output logic [XLEN-1:0]   pc_out,
    output logic              valid_out
);

    fetch_state_e      state_q, state_d;
    logic [XLEN-1:0]   pc_q, pc_d;
    logic [XLEN-1:0]   req_pc_q;      // address of the outstanding / buffered word
    logic [INSN_W-1:0] buf_q;         // word parked while decode is stalled
    logic              req_valid_q;
    logic [INSN_W-1:0] insn_q;
    logic [XLEN-1:0]   pc_out_q;
    logic              valid_q;

    logic              req_fire;
    logic              deliver_wait;
    logic              deliver_hold;

    // req_valid_q is low for the first cycle after reset even though the
    // state is FETCH_REQ, so the handshake must qualify on it.
    assign req_fire     = (state_q == FETCH_REQ) && req_valid_q && imem_req_ready;
    assign deliver_wait = (state_q == FETCH_WAIT) && imem_resp_valid && !stall && !redirect_valid;
    assign deliver_hold = (state_q == FETCH_HOLD) && !stall && !redirect_valid;

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        if (req_fire) begin
            pc_d = pc_q + 64'd4;
        end
        if (redirect_valid) begin
            pc_d = redirect_pc;
        end

        case (state_q)
            FETCH_REQ: begin
                // A request accepted in the redirect cycle is still in
                // flight; its response must be thrown away.
                if (req_fire) begin
                    state_d = redirect_valid ? FETCH_DROP : FETCH_WAIT;
                end
            end
            FETCH_WAIT: begin
                if (redirect_valid) begin
                    state_d = imem_resp_valid ? FETCH_REQ : FETCH_DROP;
                end else if (imem_resp_valid) begin
                    state_d = stall ? FETCH_HOLD : FETCH_REQ;
                end
            end
            FETCH_HOLD: begin
                if (redirect_valid || !stall) begin
                    state_d = FETCH_REQ;
                end
            end
            FETCH_DROP: begin
                // A redirect here only moves the PC; the pending response
                // is consumed whenever it shows up, even alongside a redirect.
                if (imem_resp_valid) begin
                    state_d = FETCH_REQ;
                end
            end
            default: state_d = FETCH_REQ;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= FETCH_REQ;
            pc_q        <= RESET_PC;
            req_pc_q    <= '0;
            buf_q       <= '0;
            req_valid_q <= 1'b0;
            insn_q      <= '0;
            pc_out_q    <= '0;
            valid_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            req_valid_q <= (state_d == FETCH_REQ);

            if (req_fire) begin
                req_pc_q <= pc_q;
            end
            if ((state_q == FETCH_WAIT) && imem_resp_valid) begin
                buf_q <= imem_resp_data;
            end

            // Output register: redirect clears, a new word loads, a stall
            // freezes everything, otherwise valid drops after one cycle.
            if (redirect_valid) begin
                valid_q <= 1'b0;
            end else if (deliver_wait) begin
                insn_q   <= imem_resp_data;
                pc_out_q <= req_pc_q;
                valid_q  <= 1'b1;
            end else if (deliver_hold) begin
                insn_q   <= buf_q;
                pc_out_q <= req_pc_q;
                valid_q  <= 1'b1;
            end else if (!stall) begin
                valid_q <= 1'b0;
            end
        end
    end

    assign imem_req_valid  = req_valid_q;
    assign imem_req_addr   = pc_q;
    assign instruction_out = insn_q;
    assign pc_out          = pc_out_q;
    assign valid_out       = valid_q;

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 The block SHALL have parameter RESET_PC, default 64'h0, the first fetch address after reset.
REQ-002 The block SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port reset_n, input, 1, asynchronous active-low reset.
REQ-004 The block SHALL have port imem_req_valid, output, 1, fetch request valid.
REQ-005 The block SHALL have port imem_req_ready, input, 1, memory accepts the request this cycle.
REQ-006 The block SHALL have port imem_req_addr, output, 64, fetch byte address.
REQ-007 The block SHALL have port imem_resp_valid, input, 1, instruction word returned this cycle.
REQ-008 The block SHALL have port imem_resp_data, input, 32, returned instruction word.
REQ-009 The block SHALL have port stall, input, 1, decode cannot take a new instruction.
REQ-010 The block SHALL have port redirect_valid, input, 1, branch/jump taken; flush and refetch.
REQ-011 The block SHALL have port redirect_pc, input, 64, new fetch address.
REQ-012 The block SHALL have port instruction_out, output, 32, instruction to the IF/ID stage register.
REQ-013 The block SHALL have port pc_out, output, 64, address of instruction_out.
REQ-014 The block SHALL have port valid_out, output, 1, instruction_out/pc_out carry a new instruction this cycle.

Function
REQ-015 The block SHALL use FSM states REQ (request driven), WAIT (one request outstanding), HOLD (word buffered under stall), and DROP (outstanding response to be discarded).
REQ-016 The block SHALL have at most one request outstanding; imem_req_valid is high only in REQ, with imem_req_addr = fetch pc.
REQ-017 In REQ with imem_req_ready=1, the block SHALL latch req_pc = pc, set pc to pc+4 (64-bit wrap), and go to WAIT.
REQ-018 In WAIT with imem_resp_valid=1 and stall=0, the block SHALL register instruction_out=imem_resp_data, pc_out=req_pc, valid_out=1 on the next edge, and go to REQ, giving 1 cycle response-to-output latency.
REQ-019 In WAIT with imem_resp_valid=1 and stall=1, the block SHALL buffer the word and req_pc and go to HOLD.
REQ-020 In HOLD, the block SHALL present the buffered word with valid_out=1 on the first cycle stall=0, then go to REQ; no request is issued in HOLD.
REQ-021 valid_out SHALL be high for exactly one cycle per delivered instruction; when stall=1, instruction_out, pc_out and valid_out SHALL hold their values.
REQ-022 redirect_valid SHALL take priority over all other events: pc <= redirect_pc, valid_out <= 0, and any HOLD buffer is discarded.
REQ-023 On redirect in REQ or HOLD, or in WAIT coinciding with imem_resp_valid, the block SHALL go to REQ; that response is dropped.
REQ-024 On redirect in WAIT without a response, the block SHALL go to DROP; in DROP the next imem_resp_valid is discarded and the FSM goes to REQ.
REQ-025 A redirect arriving while in DROP SHALL update pc only and remain in DROP.
REQ-026 A redirect in REQ coinciding with imem_req_ready=1 SHALL still count the request as issued and go to DROP.

Reset
REQ-027 While reset_n=0, the block SHALL hold pc=RESET_PC, FSM=REQ, imem_req_valid=0, instruction_out=32'h0, pc_out=64'h0, valid_out=0.
REQ-028 Reset asserted mid-request SHALL abandon it; after release, the first request SHALL be to RESET_PC, and a stale response arriving in REQ SHALL be ignored.

Structure
REQ-029 FSM state encodings and the instruction width (32) SHALL reside in the shared cpu package; RESET_PC stays a module parameter.
REQ-030 The block SHALL be a single module with no sub-modules; its outputs connect directly to the IF/ID stage register inputs.

Verification
REQ-031 Reset release, ready=1, 1-cycle response latency -> requests at 0x0, 0x4, 0x8; valid_out pulses with pc_out 0x0, 0x4, 0x8.
REQ-032 Stall=1 held 3 cycles when response for 0x4 arrives -> HOLD, no new request; on stall drop, valid_out=1 with pc_out=0x4.
REQ-033 Redirect to 0x100 while WAIT for 0x8 -> DROP; response for 0x8 never appears on valid_out; next request at 0x100.
REQ-034 Redirect to 0x200 in the same cycle as the response for 0xC -> word dropped; next request at 0x200.
REQ-035 imem_req_ready=0 for 5 cycles -> imem_req_valid and imem_req_addr stable throughout; pc unchanged.
REQ-036 reset_n pulsed low while in WAIT -> all outputs at reset values asynchronously; first request after release at RESET_PC.
